prog_loader: RTL

Byte-stream program loader that fills the CPU's instruction RAM before execution. It is the write-side counterpart of the instruction fetch path: the CPU only reads instruction words, and this block writes them. It holds the CPU in reset while loading and releases it once the last word is committed. Bytes arrive over a valid/ready stream, for example from a UART receiver or a test bench, and are written to the RAM write port as 32-bit words.

---
 rtl/prog_loader.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: turns a length-prefixed byte stream into 32-bit instruction RAM writes
// and holds the CPU in reset until the final word is committed. Define CHECKSUM_EN for a trailing XOR byte.
module prog_loader #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

`ifdef CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0] WL_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] WL_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       asm_q, asm_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_din_q, mem_din_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic [7:0]        csum_q, csum_d;
    logic              cpu_rst_q, cpu_rst_d;

    logic              xfer;
    logic              mismatch;
    logic              last_word;
    logic              ram_full;
    state_t            after_data;

    always_comb begin
        byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CSUM);
    end

    assign xfer       = byte_valid & byte_ready;
    assign last_word  = (word_idx_q == (len_q - 16'd1));
    // Writes only ever land at indices below the RAM depth, so the written count
    // reaching the depth means the current word index is already out of range.
    assign ram_full   = (words_loaded_q == WL_MAX);
    assign after_data = CSUM_EN ? S_CSUM : S_DONE;

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        word_idx_d     = word_idx_q;
        byte_cnt_d     = byte_cnt_q;
        asm_d          = asm_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_din_d      = mem_din_q;
        words_loaded_d = words_loaded_q;
        ovf_d          = ovf_q;
        err_d          = err_q;
        csum_d         = csum_q;
        mismatch       = 1'b0;

        if (xfer) begin
            csum_d = csum_q ^ byte_data;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d        = S_LEN_HI;
                    word_idx_d     = 16'd0;
                    byte_cnt_d     = 2'd0;
                    words_loaded_d = '0;
                    ovf_d          = 1'b0;
                    err_d          = 1'b0;
                    csum_d         = 8'd0;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = byte_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = byte_data;
                    if ({len_q[15:8], byte_data} == 16'd0) begin
                        state_d = after_data;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    asm_d      = {asm_q[15:0], byte_data};
                    if (byte_cnt_q == 2'd3) begin
                        word_idx_d = word_idx_q + 16'd1;
                        if (ram_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            mem_we_d       = 1'b1;
                            mem_addr_d     = words_loaded_q[ADDR_W-1:0];
                            mem_din_d      = {asm_q, byte_data};
                            words_loaded_d = words_loaded_q + WL_ONE;
                        end
                        if (last_word) begin
                            state_d = after_data;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    mismatch = (byte_data != csum_q);
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // err is latched once, on the transition into DONE.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            err_d = ovf_d | mismatch;
        end

        cpu_rst_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            len_q          <= 16'd0;
            word_idx_q     <= 16'd0;
            byte_cnt_q     <= 2'd0;
            asm_q          <= 24'd0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_din_q      <= 32'd0;
            words_loaded_q <= '0;
            ovf_q          <= 1'b0;
            err_q          <= 1'b0;
            csum_q         <= 8'd0;
            cpu_rst_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            word_idx_q     <= word_idx_d;
            byte_cnt_q     <= byte_cnt_d;
            asm_q          <= asm_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_din_q      <= mem_din_d;
            words_loaded_q <= words_loaded_d;
            ovf_q          <= ovf_d;
            err_q          <= err_d;
            csum_q         <= csum_d;
            cpu_rst_q      <= cpu_rst_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_din      = mem_din_q;
    assign cpu_rst      = cpu_rst_q;
    assign done         = (state_q == S_DONE);
    assign err          = err_q;
    assign words_loaded = words_loaded_q;

endmodule
